// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: RV32 opcodes, immediate formats,
// result-source and ALU-control encodings, the canonical NOP and the packed
// control bundle carried into the execute stage.
package decode_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_type_e;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_ctrl_e;

    // Controls registered into the execute stage. All-zero is a bubble.
    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       is_load;
        logic       branch;
        logic       jump;
        logic       alu_src;
        alu_ctrl_e  alu_control;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/decode_stage_pipe_imm_gen.sv
// Immediate generator: extracts the I/S/B/U/J immediate from a 32-bit RV32
// instruction and sign-extends it from instruction bit 31 to DATA_WIDTH.
// Ports:
//   ins      in   32          instruction word
//   imm_type in   imm_type_e  immediate format
//   imm_ext  out  DATA_WIDTH  sign-extended immediate
module imm_gen
    import decode_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [31:0]           ins,
    input  imm_type_e             imm_type,
    output logic [DATA_WIDTH-1:0] imm_ext
);

    logic [31:0] imm;

    always_comb begin
        case (imm_type)
            IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
            IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U:   imm = {ins[31:12], 12'b0};
            IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    assign imm_ext = DATA_WIDTH'($signed(imm));

endmodule

// File: rtl/decode_stage_pipe.sv
// Pipelined decode stage: IF/ID register, register file with write-back
// bypass, control/immediate decode, load-use hazard detection and the ID/EX
// register.
// Ports:
//   clk, rst_n                       clock (rising edge), async active-low reset
//   ins_f, pc_f, pc_plus_4_f, valid_f  fetched instruction and its PCs
//   flush                            redirect taken in E: squash D and E
//   reg_write_w, rd_w, result_w      write-back port
//   stall_f                          fetch must hold PC and instruction
//   valid_e .. rd_e                  registered E-stage instruction fields
module decode_stage_pipe
    import decode_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32,
    parameter int REG_ADDR_W = $clog2(REG_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] ins_f,
    input  logic [DATA_WIDTH-1:0] pc_f,
    input  logic [DATA_WIDTH-1:0] pc_plus_4_f,
    input  logic                  valid_f,
    input  logic                  flush,
    input  logic                  reg_write_w,
    input  logic [REG_ADDR_W-1:0] rd_w,
    input  logic [DATA_WIDTH-1:0] result_w,
    output logic                  stall_f,
    output logic                  valid_e,
    output logic                  illegal_e,
    output logic                  reg_write_e,
    output logic [1:0]            result_src_e,
    output logic                  mem_write_e,
    output logic                  is_load_e,
    output logic                  branch_e,
    output logic                  jump_e,
    output logic                  alu_src_e,
    output logic [2:0]            alu_control_e,
    output logic [DATA_WIDTH-1:0] rd1_e,
    output logic [DATA_WIDTH-1:0] rd2_e,
    output logic [DATA_WIDTH-1:0] imm_ext_e,
    output logic [DATA_WIDTH-1:0] pc_e,
    output logic [DATA_WIDTH-1:0] pc_plus_4_e,
    output logic [REG_ADDR_W-1:0] rs1_e,
    output logic [REG_ADDR_W-1:0] rs2_e,
    output logic [REG_ADDR_W-1:0] rd_e
);

    // ---------------- IF/ID register ----------------
    logic                  valid_d;
    logic [DATA_WIDTH-1:0] ins_d, pc_d, pc_plus_4_d;

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush) begin
            valid_d     <= 1'b0;
            ins_d       <= DATA_WIDTH'(NOP);
            pc_d        <= '0;
            pc_plus_4_d <= '0;
        end else if (!stall_f) begin
            valid_d     <= valid_f;
            ins_d       <= ins_f;
            pc_d        <= pc_f;
            pc_plus_4_d <= pc_plus_4_f;
        end
    end

    // ---------------- Field extraction ----------------
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic                  funct7_5;
    logic [REG_ADDR_W-1:0] rs1_d, rs2_d, rd_d;

    assign opcode   = ins_d[6:0];
    assign funct3   = ins_d[14:12];
    assign funct7_5 = ins_d[30];
    // Narrow register files simply drop the upper index bits.
    assign rd_d     = ins_d[7  +: REG_ADDR_W];
    assign rs1_d    = ins_d[15 +: REG_ADDR_W];
    assign rs2_d    = ins_d[20 +: REG_ADDR_W];

    // ---------------- Register file ----------------
    logic [DATA_WIDTH-1:0] regs [REG_COUNT];
    logic [DATA_WIDTH-1:0] rd1_d, rd2_d;

    // NOTE: this array is architectural state that must clear on reset, so it is built from resettable flops rather than a RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else if (reg_write_w && rd_w != '0) begin
            regs[rd_w] <= result_w;
        end
    end

    // Same-edge write-back is forwarded so D never sees a stale value.
    assign rd1_d = (rs1_d == '0) ? '0 :
                   (reg_write_w && rd_w == rs1_d) ? result_w : regs[rs1_d];
    assign rd2_d = (rs2_d == '0) ? '0 :
                   (reg_write_w && rd_w == rs2_d) ? result_w : regs[rs2_d];

    // ---------------- Control decode ----------------
    ctrl_t     ctrl_d;
    imm_type_e imm_type_d;
    alu_ctrl_e alu_funct;
    logic      uses_rs1, uses_rs2;

    // The 3-bit ALU encoding has no unsigned compare or arithmetic shift,
    // so SLTU folds into SLT and SRA into SRL.
    always_comb begin
        case (funct3)
            3'b000:         alu_funct = ALU_ADD;
            3'b001:         alu_funct = ALU_SLL;
            3'b010, 3'b011: alu_funct = ALU_SLT;
            3'b100:         alu_funct = ALU_XOR;
            3'b101:         alu_funct = ALU_SRL;
            3'b110:         alu_funct = ALU_OR;
            default:        alu_funct = ALU_AND;
        endcase
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        ctrl_d     = '0;
        imm_type_d = IMM_I;
        uses_rs1   = 1'b0;
        uses_rs2   = 1'b0;
        case (opcode)
            OP_R: begin
                ctrl_d.reg_write   = 1'b1;
                ctrl_d.alu_control = (funct3 == 3'b000 && funct7_5) ? ALU_SUB : alu_funct;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_I: begin
                ctrl_d.reg_write   = 1'b1;
                ctrl_d.alu_src     = 1'b1;
                ctrl_d.alu_control = alu_funct;
                uses_rs1 = 1'b1;
            end
            OP_LOAD: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.result_src = RES_MEM;
                ctrl_d.is_load    = 1'b1;
                ctrl_d.alu_src    = 1'b1;
                uses_rs1 = 1'b1;
            end
            OP_STORE: begin
                ctrl_d.mem_write = 1'b1;
                ctrl_d.alu_src   = 1'b1;
                imm_type_d = IMM_S;
                uses_rs1   = 1'b1;
                uses_rs2   = 1'b1;
            end
            OP_BRANCH: begin
                ctrl_d.branch      = 1'b1;
                ctrl_d.alu_control = ALU_SUB;
                imm_type_d = IMM_B;
                uses_rs1   = 1'b1;
                uses_rs2   = 1'b1;
            end
            OP_JAL: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.result_src = RES_PC4;
                ctrl_d.jump       = 1'b1;
                imm_type_d = IMM_J;
            end
            OP_JALR: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.result_src = RES_PC4;
                ctrl_d.jump       = 1'b1;
                ctrl_d.alu_src    = 1'b1;
                uses_rs1 = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_src   = 1'b1;
                imm_type_d = IMM_U;
            end
            default: ctrl_d.illegal = 1'b1;
        endcase
    end

    logic [DATA_WIDTH-1:0] imm_ext_d;

    imm_gen #(.DATA_WIDTH(DATA_WIDTH)) u_imm_gen (
        .ins      (ins_d[31:0]),
        .imm_type (imm_type_d),
        .imm_ext  (imm_ext_d)
    );

    // ---------------- Load-use hazard ----------------
    logic hz;

    assign hz = valid_d && valid_e && is_load_e && (rd_e != '0) &&
                ((uses_rs1 && rd_e == rs1_d) || (uses_rs2 && rd_e == rs2_d));
    // A redirect discards the dependent instruction anyway, so it never stalls.
    assign stall_f = hz && !flush;

    // ---------------- ID/EX register ----------------
    ctrl_t ctrl_e;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush || hz) begin
            valid_e     <= 1'b0;
            ctrl_e      <= '0;
            rd1_e       <= '0;
            rd2_e       <= '0;
            imm_ext_e   <= '0;
            pc_e        <= '0;
            pc_plus_4_e <= '0;
            rs1_e       <= '0;
            rs2_e       <= '0;
            rd_e        <= '0;
        end else begin
            valid_e     <= valid_d;
            ctrl_e      <= ctrl_d;
            rd1_e       <= rd1_d;
            rd2_e       <= rd2_d;
            imm_ext_e   <= imm_ext_d;
            pc_e        <= pc_d;
            pc_plus_4_e <= pc_plus_4_d;
            rs1_e       <= rs1_d;
            rs2_e       <= rs2_d;
            rd_e        <= rd_d;
        end
    end

    assign illegal_e     = ctrl_e.illegal;
    assign reg_write_e   = ctrl_e.reg_write;
    assign result_src_e  = ctrl_e.result_src;
    assign mem_write_e   = ctrl_e.mem_write;
    assign is_load_e     = ctrl_e.is_load;
    assign branch_e      = ctrl_e.branch;
    assign jump_e        = ctrl_e.jump;
    assign alu_src_e     = ctrl_e.alu_src;
    assign alu_control_e = ctrl_e.alu_control;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed testbench for decode_stage_pipe. One instance with 32 registers
// and one with 16 share all inputs; expected values are hand-computed.
module tb_decode_stage_pipe;

    localparam logic [31:0] I_NOP    = 32'h0000_0013; // addi x0,x0,0
    localparam logic [31:0] I_LW     = 32'h0000_A283; // lw   x5,0(x1)
    localparam logic [31:0] I_ADD6   = 32'h0022_8333; // add  x6,x5,x2
    localparam logic [31:0] I_ADD4   = 32'h0001_8233; // add  x4,x3,x0
    localparam logic [31:0] I_ADDI1  = 32'h0000_0093; // addi x1,x0,0
    localparam logic [31:0] I_BEQ    = 32'hFE00_0CE3; // beq  x0,x0,-8
    localparam logic [31:0] I_JAL    = 32'h0010_00EF; // jal  x1,+2048
    localparam logic [31:0] I_SW     = 32'hFE20_AE23; // sw   x2,-4(x1)
    localparam logic [31:0] I_LUI    = 32'h1234_53B7; // lui  x7,0x12345
    localparam logic [31:0] I_ADDI17 = 32'h0008_8113; // addi x2,x17,0
    localparam logic [31:0] I_ILL    = 32'h0000_007F;

    logic        clk, rst_n;
    logic [31:0] ins_f, pc_f, pc_plus_4_f, result_w;
    logic        valid_f, flush, reg_write_w;
    logic [4:0]  rd_w;

    logic        stall_f, valid_e, illegal_e, reg_write_e, mem_write_e, is_load_e;
    logic        branch_e, jump_e, alu_src_e;
    logic [1:0]  result_src_e;
    logic [2:0]  alu_control_e;
    logic [31:0] rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus_4_e;
    logic [4:0]  rs1_e, rs2_e, rd_e;

    logic        stall_f_16, valid_e_16, illegal_e_16, reg_write_e_16, mem_write_e_16;
    logic        is_load_e_16, branch_e_16, jump_e_16, alu_src_e_16;
    logic [1:0]  result_src_e_16;
    logic [2:0]  alu_control_e_16;
    logic [31:0] rd1_e_16, rd2_e_16, imm_ext_e_16, pc_e_16, pc_plus_4_e_16;
    logic [3:0]  rs1_e_16, rs2_e_16, rd_e_16;

    int errors = 0;
    int checks = 0;

    decode_stage_pipe #(.DATA_WIDTH(32), .REG_COUNT(32)) dut (
        .clk(clk), .rst_n(rst_n), .ins_f(ins_f), .pc_f(pc_f), .pc_plus_4_f(pc_plus_4_f),
        .valid_f(valid_f), .flush(flush), .reg_write_w(reg_write_w), .rd_w(rd_w),
        .result_w(result_w), .stall_f(stall_f), .valid_e(valid_e), .illegal_e(illegal_e),
        .reg_write_e(reg_write_e), .result_src_e(result_src_e), .mem_write_e(mem_write_e),
        .is_load_e(is_load_e), .branch_e(branch_e), .jump_e(jump_e), .alu_src_e(alu_src_e),
        .alu_control_e(alu_control_e), .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_ext_e(imm_ext_e),
        .pc_e(pc_e), .pc_plus_4_e(pc_plus_4_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e)
    );

    decode_stage_pipe #(.DATA_WIDTH(32), .REG_COUNT(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .ins_f(ins_f), .pc_f(pc_f), .pc_plus_4_f(pc_plus_4_f),
        .valid_f(valid_f), .flush(flush), .reg_write_w(reg_write_w), .rd_w(rd_w[3:0]),
        .result_w(result_w), .stall_f(stall_f_16), .valid_e(valid_e_16),
        .illegal_e(illegal_e_16), .reg_write_e(reg_write_e_16),
        .result_src_e(result_src_e_16), .mem_write_e(mem_write_e_16),
        .is_load_e(is_load_e_16), .branch_e(branch_e_16), .jump_e(jump_e_16),
        .alu_src_e(alu_src_e_16), .alu_control_e(alu_control_e_16), .rd1_e(rd1_e_16),
        .rd2_e(rd2_e_16), .imm_ext_e(imm_ext_e_16), .pc_e(pc_e_16),
        .pc_plus_4_e(pc_plus_4_e_16), .rs1_e(rs1_e_16), .rs2_e(rs2_e_16), .rd_e(rd_e_16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_f(input logic [31:0] ins, input logic [31:0] pc, input logic valid);
        ins_f       = ins;
        pc_f        = pc;
        pc_plus_4_f = pc + 32'd4;
        valid_f     = valid;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        set_f(I_NOP, 32'h0, 1'b0);
        flush = 1'b0; reg_write_w = 1'b0; rd_w = '0; result_w = '0;
        #1 rst_n = 1'b0;
        #1;
        // Every output of both instances must be zero while reset is held.
        checks++; if ({stall_f, valid_e, illegal_e, reg_write_e, result_src_e, mem_write_e, is_load_e, branch_e, jump_e, alu_src_e, alu_control_e} !== '0)
            begin errors++; $display("FAIL reset_ctrl32: got %b expected 0", {stall_f, valid_e, illegal_e, reg_write_e, result_src_e, mem_write_e, is_load_e, branch_e, jump_e, alu_src_e, alu_control_e}); end
        checks++; if ({rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus_4_e, rs1_e, rs2_e, rd_e} !== '0)
            begin errors++; $display("FAIL reset_data32: got %h expected 0", {rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus_4_e, rs1_e, rs2_e, rd_e}); end
        checks++; if ({stall_f_16, valid_e_16, illegal_e_16, reg_write_e_16, result_src_e_16, mem_write_e_16, is_load_e_16, branch_e_16, jump_e_16, alu_src_e_16, alu_control_e_16} !== '0)
            begin errors++; $display("FAIL reset_ctrl16: got %b expected 0", {stall_f_16, valid_e_16, illegal_e_16, reg_write_e_16, result_src_e_16, mem_write_e_16, is_load_e_16, branch_e_16, jump_e_16, alu_src_e_16, alu_control_e_16}); end
        checks++; if ({rd1_e_16, rd2_e_16, imm_ext_e_16, pc_e_16, pc_plus_4_e_16, rs1_e_16, rs2_e_16, rd_e_16} !== '0)
            begin errors++; $display("FAIL reset_data16: got %h expected 0", {rd1_e_16, rd2_e_16, imm_ext_e_16, pc_e_16, pc_plus_4_e_16, rs1_e_16, rs2_e_16, rd_e_16}); end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_load_use();
        set_f(I_LW, 32'h100, 1'b1);   tick();  // lw in D
        set_f(I_ADD6, 32'h104, 1'b1); tick();  // lw in E, add in D
        checks++; if (is_load_e !== 1'b1 || rd_e !== 5'd5) begin errors++; $display("FAIL lu_load_in_e: got is_load=%b rd=%0d expected 1/5", is_load_e, rd_e); end
        checks++; if (stall_f !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b expected 1", stall_f); end
        set_f(I_NOP, 32'h108, 1'b1);  tick();  // bubble into E, add held in D
        checks++; if (valid_e !== 1'b0) begin errors++; $display("FAIL lu_bubble: got valid_e=%b expected 0", valid_e); end
        checks++; if (stall_f !== 1'b0) begin errors++; $display("FAIL lu_stall_one_cycle: got %b expected 0", stall_f); end
        tick();                                // add reaches E
        checks++; if (valid_e !== 1'b1 || rs1_e !== 5'd5 || rs2_e !== 5'd2 || rd_e !== 5'd6)
            begin errors++; $display("FAIL lu_add_e: got v=%b rs1=%0d rs2=%0d rd=%0d expected 1/5/2/6", valid_e, rs1_e, rs2_e, rd_e); end
        checks++; if (pc_e !== 32'h104 || pc_plus_4_e !== 32'h108 || reg_write_e !== 1'b1 || alu_src_e !== 1'b0)
            begin errors++; $display("FAIL lu_add_fields: got pc=%h pc4=%h rw=%b as=%b expected 104/108/1/0", pc_e, pc_plus_4_e, reg_write_e, alu_src_e); end
    endtask

    task automatic test_bypass();
        set_f(I_ADD4, 32'h200, 1'b1); tick();
        reg_write_w = 1'b1; rd_w = 5'd3; result_w = 32'hDEAD_BEEF;
        set_f(I_NOP, 32'h204, 1'b1); tick();
        reg_write_w = 1'b0;
        checks++; if (rd1_e !== 32'hDEAD_BEEF || rs1_e !== 5'd3 || rd_e !== 5'd4 || rd2_e !== 32'h0)
            begin errors++; $display("FAIL bypass: got rd1=%h rs1=%0d rd=%0d rd2=%h expected deadbeef/3/4/0", rd1_e, rs1_e, rd_e, rd2_e); end
        set_f(I_ADD4, 32'h208, 1'b1); tick();
        set_f(I_NOP, 32'h20C, 1'b1);  tick();
        checks++; if (rd1_e !== 32'hDEAD_BEEF) begin errors++; $display("FAIL regfile_write32: got %h expected deadbeef", rd1_e); end
        checks++; if (rd1_e_16 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL regfile_write16: got %h expected deadbeef", rd1_e_16); end
    endtask

    task automatic test_x0_write();
        set_f(I_ADDI1, 32'h300, 1'b1); tick();
        reg_write_w = 1'b1; rd_w = 5'd0; result_w = 32'hFFFF_FFFF;
        set_f(I_NOP, 32'h304, 1'b1); tick();
        reg_write_w = 1'b0;
        checks++; if (rd1_e !== 32'h0) begin errors++; $display("FAIL x0_no_bypass: got %h expected 0", rd1_e); end
        set_f(I_ADDI1, 32'h308, 1'b1); tick();
        set_f(I_NOP, 32'h30C, 1'b1);   tick();
        checks++; if (rd1_e !== 32'h0 || reg_write_e !== 1'b1 || alu_src_e !== 1'b1 || rd_e !== 5'd1)
            begin errors++; $display("FAIL x0_write_dropped: got rd1=%h rw=%b as=%b rd=%0d expected 0/1/1/1", rd1_e, reg_write_e, alu_src_e, rd_e); end
    endtask

    task automatic test_flush_during_hz();
        set_f(I_LW, 32'h400, 1'b1);   tick();
        set_f(I_ADD6, 32'h404, 1'b1); tick();
        checks++; if (stall_f !== 1'b1) begin errors++; $display("FAIL fl_hz_setup: got %b expected 1", stall_f); end
        flush = 1'b1;
        #1;
        checks++; if (stall_f !== 1'b0) begin errors++; $display("FAIL fl_stall_masked: got %b expected 0", stall_f); end
        set_f(I_ADDI1, 32'h408, 1'b1); tick();
        flush = 1'b0;
        checks++; if (valid_e !== 1'b0 || reg_write_e !== 1'b0 || is_load_e !== 1'b0 || stall_f !== 1'b0)
            begin errors++; $display("FAIL fl_e_bubble: got v=%b rw=%b ld=%b st=%b expected 0/0/0/0", valid_e, reg_write_e, is_load_e, stall_f); end
        set_f(I_NOP, 32'h40C, 1'b0); tick();
        // IF/ID held a NOP bubble: decodes as addi x0 with valid clear.
        checks++; if (valid_e !== 1'b0 || alu_src_e !== 1'b1 || rd_e !== 5'd0 || imm_ext_e !== 32'h0 || illegal_e !== 1'b0)
            begin errors++; $display("FAIL fl_d_nop: got v=%b as=%b rd=%0d imm=%h ill=%b expected 0/1/0/0/0", valid_e, alu_src_e, rd_e, imm_ext_e, illegal_e); end
    endtask

    task automatic test_immediates();
        set_f(I_BEQ, 32'h500, 1'b1); tick();
        set_f(I_JAL, 32'h504, 1'b1); tick();
        checks++; if (imm_ext_e !== 32'hFFFF_FFF8 || branch_e !== 1'b1 || jump_e !== 1'b0 || reg_write_e !== 1'b0 || alu_control_e !== 3'b001)
            begin errors++; $display("FAIL imm_beq: got imm=%h br=%b j=%b rw=%b alu=%b expected fffffff8/1/0/0/001", imm_ext_e, branch_e, jump_e, reg_write_e, alu_control_e); end
        set_f(I_SW, 32'h508, 1'b1); tick();
        checks++; if (imm_ext_e !== 32'h0000_0800 || jump_e !== 1'b1 || result_src_e !== 2'b10 || rd_e !== 5'd1 || reg_write_e !== 1'b1 || pc_plus_4_e !== 32'h508)
            begin errors++; $display("FAIL imm_jal: got imm=%h j=%b rs=%b rd=%0d rw=%b pc4=%h expected 800/1/10/1/1/508", imm_ext_e, jump_e, result_src_e, rd_e, reg_write_e, pc_plus_4_e); end
        set_f(I_LUI, 32'h50C, 1'b1); tick();
        checks++; if (imm_ext_e !== 32'hFFFF_FFFC || mem_write_e !== 1'b1 || reg_write_e !== 1'b0 || rs2_e !== 5'd2)
            begin errors++; $display("FAIL imm_sw: got imm=%h mw=%b rw=%b rs2=%0d expected fffffffc/1/0/2", imm_ext_e, mem_write_e, reg_write_e, rs2_e); end
        set_f(I_NOP, 32'h510, 1'b1); tick();
        checks++; if (imm_ext_e !== 32'h1234_5000 || reg_write_e !== 1'b1 || alu_src_e !== 1'b1 || rd_e !== 5'd7)
            begin errors++; $display("FAIL imm_lui: got imm=%h rw=%b as=%b rd=%0d expected 12345000/1/1/7", imm_ext_e, reg_write_e, alu_src_e, rd_e); end
    endtask

    task automatic test_reg_count_16();
        reg_write_w = 1'b1; rd_w = 5'd1; result_w = 32'h1234_5678;
        set_f(I_NOP, 32'h600, 1'b1); tick();
        reg_write_w = 1'b0;
        set_f(I_ADDI17, 32'h604, 1'b1); tick();
        set_f(I_ILL, 32'h608, 1'b1);    tick();
        checks++; if (rd1_e_16 !== 32'h1234_5678 || rs1_e_16 !== 4'd1)
            begin errors++; $display("FAIL rc16_idx_wrap: got rd1=%h rs1=%0d expected 12345678/1", rd1_e_16, rs1_e_16); end
        checks++; if (rd1_e !== 32'h0 || rs1_e !== 5'd17)
            begin errors++; $display("FAIL rc32_idx_full: got rd1=%h rs1=%0d expected 0/17", rd1_e, rs1_e); end
        set_f(I_NOP, 32'h60C, 1'b1); tick();
        checks++; if (illegal_e_16 !== 1'b1 || valid_e_16 !== 1'b1 || {reg_write_e_16, mem_write_e_16, branch_e_16, jump_e_16} !== 4'b0)
            begin errors++; $display("FAIL rc16_illegal: got ill=%b v=%b ctl=%b expected 1/1/0000", illegal_e_16, valid_e_16, {reg_write_e_16, mem_write_e_16, branch_e_16, jump_e_16}); end
        checks++; if (illegal_e !== 1'b1 || {reg_write_e, mem_write_e, branch_e, jump_e} !== 4'b0)
            begin errors++; $display("FAIL rc32_illegal: got ill=%b ctl=%b expected 1/0000", illegal_e, {reg_write_e, mem_write_e, branch_e, jump_e}); end
    endtask

    task automatic test_reset_mid_stream();
        set_f(I_LW, 32'h700, 1'b1);   tick();
        set_f(I_ADD6, 32'h704, 1'b1); tick();
        checks++; if (stall_f !== 1'b1 || valid_e !== 1'b1) begin errors++; $display("FAIL rst_setup: got st=%b v=%b expected 1/1", stall_f, valid_e); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({stall_f, valid_e, is_load_e, reg_write_e, result_src_e, alu_src_e, alu_control_e} !== '0 || {rd1_e, imm_ext_e, pc_e, rs1_e, rd_e} !== '0)
            begin errors++; $display("FAIL rst_async32: got ctl=%b data=%h expected 0", {stall_f, valid_e, is_load_e, reg_write_e, result_src_e, alu_src_e, alu_control_e}, {rd1_e, imm_ext_e, pc_e, rs1_e, rd_e}); end
        checks++; if ({stall_f_16, valid_e_16, is_load_e_16, rd_e_16} !== '0)
            begin errors++; $display("FAIL rst_async16: got %b expected 0", {stall_f_16, valid_e_16, is_load_e_16, rd_e_16}); end
        set_f(I_ADD4, 32'h800, 1'b1);
        @(negedge clk) rst_n = 1'b1;
        tick();
        set_f(I_NOP, 32'h804, 1'b1); tick();
        // x3 held deadbeef before reset; it must read back as zero now.
        checks++; if (rd1_e !== 32'h0 || valid_e !== 1'b1 || rd_e !== 5'd4 || pc_e !== 32'h800)
            begin errors++; $display("FAIL rst_release32: got rd1=%h v=%b rd=%0d pc=%h expected 0/1/4/800", rd1_e, valid_e, rd_e, pc_e); end
        checks++; if (rd1_e_16 !== 32'h0 || valid_e_16 !== 1'b1)
            begin errors++; $display("FAIL rst_release16: got rd1=%h v=%b expected 0/1", rd1_e_16, valid_e_16); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_bypass();
        test_x0_write();
        test_flush_during_hz();
        test_immediates();
        test_reg_count_16();
        test_reset_mid_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
- Pipelined successor to the current combinational decode stage.
- Owns the IF/ID pipeline register, a parametrised register file with write-back bypass, control and immediate decode, load-use hazard detection, and the ID/EX pipeline register.
- Sits between fetch and execute. Generates the fetch stall and accepts an execute-stage redirect flush.
- Supports RV32I (REG_COUNT=32) and RV32E (REG_COUNT=16) register files.

Parameters:
- DATA_WIDTH, 32, datapath, PC and immediate width.
- REG_COUNT, 32, number of architectural registers (16 or 32).
- REG_ADDR_W, $clog2(REG_COUNT), register index width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ins_f  in  DATA_WIDTH  fetched instruction.
- pc_f  in  DATA_WIDTH  PC of ins_f.
- pc_plus_4_f  in  DATA_WIDTH  pc_f+4.
- valid_f  in  1  ins_f is valid.
- flush  in  1  branch/jump taken in E; squash D and E.
- reg_write_w  in  1  write-back enable.
- rd_w  in  REG_ADDR_W  write-back register.
- result_w  in  DATA_WIDTH  write-back data.
- stall_f  out  1  fetch must hold PC and ins_f.
- valid_e  out  1  E-stage slot holds a real instruction.
- illegal_e  out  1  unrecognised opcode in E.
- reg_write_e  out  1  registered control.
- result_src_e  out  2  registered control: 00 ALU, 01 mem, 10 pc+4.
- mem_write_e  out  1  registered control.
- is_load_e  out  1  registered control.
- branch_e  out  1  registered control.
- jump_e  out  1  registered control.
- alu_src_e  out  1  registered control.
- alu_control_e  out  3  registered control, encoding from package.
- rd1_e  out  DATA_WIDTH  operand from rs1.
- rd2_e  out  DATA_WIDTH  operand from rs2.
- imm_ext_e  out  DATA_WIDTH  sign-extended immediate.
- pc_e  out  DATA_WIDTH  PC of the E-stage instruction.
- pc_plus_4_e  out  DATA_WIDTH  PC+4 of the E-stage instruction.
- rs1_e  out  REG_ADDR_W  source index for the forwarding unit.
- rs2_e  out  REG_ADDR_W  source index for the forwarding unit.
- rd_e  out  REG_ADDR_W  destination index.

Behaviour:
- Reset (rst_n low, asynchronous):
  - IF/ID: valid_d=0, ins_d=NOP (0x00000013), pc_d=0.
  - All register-file entries = 0.
  - All *_e outputs = 0.
  - stall_f = 0.
- IF/ID register, one of the following each rising edge, in priority order:
  - flush: load bubble (valid_d=0, ins_d=NOP).
  - else stall_f: hold contents.
  - else: load ins_f, pc_f, pc_plus_4_f, valid_f.
- Register file:
  - Write at the rising edge when reg_write_w=1 and rd_w!=0; writes to x0 are dropped.
  - Reads are combinational.
  - Bypass: if reg_write_w && rd_w==rsN && rsN!=0, the read returns result_w.
  - x0 always reads 0.
  - With REG_COUNT=16, index bit 4 of the instruction fields is ignored.
- Decode:
  - Opcodes: R, I-ALU, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC.
  - Immediate types: I, S, B, U, J, sign-extended from instruction bit 31 to DATA_WIDTH.
  - Unrecognised opcode: illegal_e=1; all write/mem/branch/jump controls 0; valid_e follows valid_d.
- Load-use hazard:
  - hz = valid_d & valid_e & is_load_e & (rd_e!=0) & ((uses_rs1 & rd_e==rs1_d) | (uses_rs2 & rd_e==rs2_d)).
  - uses_rs1 and uses_rs2 are derived from the opcode; LUI, AUIPC and JAL use neither.
  - stall_f = hz & ~flush.
- ID/EX register, one of the following each rising edge, in priority order:
  - flush: bubble.
  - else hz: bubble.
  - else: load the decoded fields.
- Bubble contents: valid_e=0, all controls 0, rd_e=0, illegal_e=0. Data fields are don't-care but are driven 0.
- Latency: an instruction entering IF/ID at edge n appears on the *_e outputs after edge n+1. A load-use stall adds exactly one cycle.
- Simultaneous events:
  - flush with hz: flush wins, stall_f=0, both stages are bubbled.
  - Write-back to a register read by the instruction in D at the same edge: the bypass supplies the new value.
- Reset mid-operation: all state clears immediately and asynchronously. The first valid instruction after rst_n deassertion is decoded normally.

Decomposition:
- Shared package decode_pkg holds:
  - opcode constants;
  - imm_type_e enum (I, S, B, U, J);
  - result_src encodings;
  - alu_control encodings (ADD 000, SUB 001, AND 010, OR 011, XOR 100, SLT 101, SLL 110, SRL 111);
  - NOP constant;
  - a packed ctrl_t struct for the E-stage controls.
- One sub-module, imm_gen: combinational; inputs ins and imm_type; output imm_ext.
- The register file stays inline, parametrised by REG_COUNT.

Test Plan:
- Load-use: lw x5,0(x1) then add x6,x5,x2 -> stall_f=1 for exactly 1 cycle; one bubble (valid_e=0) in E; add reaches E one cycle later with rs1_e=5.
- Bypass: reg_write_w=1, rd_w=3, result_w=0xDEADBEEF while add x4,x3,x0 sits in D -> next cycle rd1_e=0xDEADBEEF.
- x0 write: reg_write_w=1, rd_w=0, result_w=0xFFFFFFFF, then addi x1,x0,0 -> rd1_e=0.
- flush during hz: assert flush in the same cycle the load-use hazard fires -> stall_f=0; next cycle valid_e=0 and IF/ID holds NOP.
- Immediate: beq with offset -8 (ins 0xFE000CE3) -> imm_ext_e=0xFFFFFFF8, branch_e=1. jal x1,+2048 -> imm_ext_e=0x00000800, jump_e=1, result_src_e=10.
- Reset mid-stream: drop rst_n between edges -> all *_e outputs and stall_f are 0 before the next edge; registers read 0 after release. Repeat with REG_COUNT=16 and confirm the illegal opcode 0x0000007F gives illegal_e=1.
